// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator. Drives the synchronous instruction memory
// address, presents the fetched instruction and its PC to decode, replays
// the current slot on a load-use hold, and squashes the wrong-path slot on
// an execute-stage redirect while raising control_hazards_sum for a fixed
// flush window.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   BOOT  | memory latency fill after reset, nothing valid on rdata
//   RUN   | streaming; hold replays the current instruction
//   FLUSH | target path streaming, hazard window still open, hold ignored
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h4000_0000,
    parameter logic [31:0] NOP          = 32'h0000_0013,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] inst_fetch,
    output logic [31:0] pc_fetch,
    output logic        inst_valid,
    output logic        control_hazards_sum
);

    localparam int CW = $clog2(FLUSH_CYCLES) + 1;
    // Counter value loaded on a redirect; the redirect cycle itself is the
    // first cycle of the window, so FLUSH covers the remaining ones.
    localparam logic [CW-1:0] RELOAD = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t        state;
    logic [31:0]   pc_q;
    logic [CW-1:0] cnt;
    logic          hold_eff;
    logic [31:0]   next_pc;

    assign hold_eff = hold & (state == RUN) & ~redirect_valid;

    // Next fetch address: reset/boot pin to RESET_PC, redirect wins over hold.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (rst) begin
            next_pc = RESET_PC;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (state == BOOT) begin
            next_pc = RESET_PC;
        end else if (hold_eff) begin
            next_pc = pc_q;
        end
    end

    assign imem_addr = next_pc;

    // Decode-facing outputs, combinational from state and the current inputs.
    always_comb begin
        inst_fetch          = imem_rdata;
        pc_fetch            = pc_q;
        inst_valid          = 1'b1;
        control_hazards_sum = 1'b0;
        if (rst) begin
            inst_fetch = NOP;
            pc_fetch   = RESET_PC;
            inst_valid = 1'b0;
        end else if (redirect_valid) begin
            inst_fetch          = NOP;
            inst_valid          = 1'b0;
            control_hazards_sum = 1'b1;
        end else if (state == BOOT) begin
            inst_fetch = NOP;
            pc_fetch   = RESET_PC;
            inst_valid = 1'b0;
        end else if (state == FLUSH) begin
            control_hazards_sum = 1'b1;
        end
    end

    // PC register, FSM and flush-window counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc_q  <= RESET_PC;
            cnt   <= '0;
        end else begin
            pc_q <= next_pc;
            if (redirect_valid) begin
                state <= (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                cnt   <= RELOAD;
            end else begin
                case (state)
                    BOOT: state <= RUN;
                    FLUSH: begin
                        if (cnt == '0) begin
                            state <= RUN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-stage PC generator and instruction presenter sitting upstream of the decode-stage control unit. Drives the synchronous instruction memory address, presents the fetched instruction and its PC to decode, and responds to decode's load-use `hold` by replaying the current instruction. Honours execute-stage branch/jump redirects by squashing the wrong-path instruction and asserting `control_hazards_sum` for a fixed flush window.

## Interface
Parameters:
- `RESET_PC`, 32'h4000_0000, first PC fetched after reset
- `NOP`, 32'h0000_0013, instruction substituted for squashed/invalid slots
- `FLUSH_CYCLES`, 2, cycles `control_hazards_sum` stays high per redirect (≥1)

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset, synchronous, active-high
- `hold`  in  1  load-use stall request from decode control, combinational from `inst_fetch`
- `redirect_valid`  in  1  taken branch/jump resolved in execute
- `redirect_pc`  in  32  target PC, valid with `redirect_valid`
- `imem_rdata`  in  32  instruction read data, one cycle after `imem_addr`
- `imem_addr`  out  32  combinational next-PC address to instruction memory
- `inst_fetch`  out  32  instruction presented to decode
- `pc_fetch`  out  32  PC of `inst_fetch`
- `inst_valid`  out  1  `inst_fetch` is a real instruction (0 for NOP substitutes)
- `control_hazards_sum`  out  1  flush window active

## Operation
- State: `pc_q` (32b, PC of instruction on `imem_rdata` this cycle), FSM {BOOT, RUN, FLUSH}, flush counter `cnt` (width clog2(FLUSH_CYCLES)+1).
- During `rst`: `imem_addr`=RESET_PC; next state BOOT, `pc_q`<=RESET_PC, `cnt`<=0. Outputs while `rst` high: `inst_fetch`=NOP, `pc_fetch`=RESET_PC, `inst_valid`=0, `control_hazards_sum`=0.
- BOOT (one cycle, memory latency fill): `imem_addr`=RESET_PC, outputs as in reset, `pc_q` unchanged; next RUN.
- RUN: `inst_fetch`=`imem_rdata`, `pc_fetch`=`pc_q`, `inst_valid`=1, `control_hazards_sum`=0.
- Effective hold `hold_eff` = `hold` & state==RUN & ~`redirect_valid`.
- Next PC: `redirect_valid` ? `redirect_pc` : `hold_eff` ? `pc_q` : `pc_q`+4 (mod 2^32, wraps silently). `imem_addr`=next PC; `pc_q`<=next PC. In BOOT without redirect, next PC = RESET_PC.
- Hold: same address re-issued, so the identical instruction/PC is presented next cycle. Consecutive holds are legal; each repeats.
- Redirect (any state except reset, priority over hold): this cycle `inst_fetch`=NOP, `inst_valid`=0, `control_hazards_sum`=1, `pc_fetch`=`pc_q`. If FLUSH_CYCLES==1 next state RUN; else next FLUSH with `cnt`<=FLUSH_CYCLES-2.
- FLUSH: `control_hazards_sum`=1; `inst_fetch`=`imem_rdata`, `pc_fetch`=`pc_q`, `inst_valid`=1 (target path, real); `hold` ignored; PC advances by 4. If `cnt`==0 next RUN, else `cnt`-1.
- Redirect during FLUSH: treated as a fresh redirect (current slot squashed, counter reloaded, new target).
- `redirect_pc` low two bits passed through unchanged; alignment is not checked.

## Timing
- Instruction-memory latency 1: address driven combinationally in cycle t, data consumed in t+1.
- Redirect in cycle t: target instruction at `inst_fetch` in t+1; `control_hazards_sum` high t..t+FLUSH_CYCLES-1.
- Hold in cycle t: `pc_fetch` at t+1 equals `pc_fetch` at t; no bubble inserted by this block.
- Reset release at cycle r: BOOT at r, first valid instruction (RESET_PC) at r+1.
- `rst` mid-FLUSH: counter cleared, `control_hazards_sum` low the cycle `rst` is sampled, BOOT follows.
- All outputs are combinational from state plus `hold`/`redirect_valid`/`imem_rdata`; no output register.

## Test plan
- Reset: hold `rst` 3 cycles -> `imem_addr`=0x4000_0000, `inst_fetch`=0x13, `inst_valid`=0, `control_hazards_sum`=0; BOOT one cycle; next cycle `pc_fetch`=0x4000_0000, `imem_addr`=0x4000_0004.
- Streaming: memory model returns data=address -> `pc_fetch`/`inst_fetch` 0x4000_0000, _0004, _0008, _000C on consecutive cycles, `inst_valid`=1.
- Hold at `pc_fetch`=0x4000_0008 one cycle -> `imem_addr`=0x4000_0008 that cycle; next cycle `pc_fetch`=0x4000_0008 again; then 0x4000_000C.
- Redirect at `pc_fetch`=0x4000_0010 to 0x4000_0100 -> that cycle `inst_fetch`=0x13, `inst_valid`=0, `control_hazards_sum`=1, `imem_addr`=0x4000_0100; next `pc_fetch`=0x4000_0100, `inst_valid`=1, `control_hazards_sum`=1; next 0x4000_0104 with `control_hazards_sum`=0.
- `hold` asserted in redirect cycle and FLUSH cycle -> ignored, PC still advances 0x4000_0100 -> 0x4000_0104.
- Redirect to 0x4000_0200 during FLUSH -> window restarts (2 more high cycles); `rst` asserted mid-FLUSH -> `control_hazards_sum`=0 immediately, restart at 0x4000_0000.
